// File: rtl/alu_responder_pkg.sv
// Shared types and constants for the ALU responder.
package alu_responder_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned MOVI_W = 2;

   // Opcode map presented by the driver
   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MULT = 4'd2,
      OP_SHL  = 4'd3,
      OP_SHR  = 4'd4,
      OP_ROL  = 4'd5,
      OP_ROR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_AND  = 4'd8,
      OP_OR   = 4'd9,
      OP_XOR  = 4'd10,
      OP_NAND = 4'd11,
      OP_NOR  = 4'd12,
      OP_XNOR = 4'd13,
      OP_INC  = 4'd14,
      OP_DEC  = 4'd15
   } alu_op_t;

   // Operand-B source select; both 00 and 11 pick REG_B
   typedef enum logic [MOVI_W-1:0] {
      MOVI_REG_B  = 2'd0,
      MOVI_MEM    = 2'd1,
      MOVI_IMM    = 2'd2,
      MOVI_REG_B2 = 2'd3
   } alu_movi_t;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, bit 0 folded
// into the start edge so the full product is ready DATA_WIDTH edges after start.
// done/product are combinational: product is valid in the cycle done is high
// and is what the accumulator takes on the following edge.
module alu_mult_seq
#(
   parameter int unsigned DATA_WIDTH = 8
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     a,
   input  logic [DATA_WIDTH-1:0]     b,
   output logic                      busy,
   output logic                      done,
   output logic [2*DATA_WIDTH-1:0]   product
);

   localparam int unsigned P_W   = 2 * DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

   logic [CNT_W-1:0]      count;
   logic [P_W-1:0]        acc;
   logic [P_W-1:0]        mcand;
   logic [P_W-1:0]        partial;
   logic [DATA_WIDTH-1:0] mplier;

   assign partial = mplier[0] ? mcand : '0;
   assign product = acc + partial;
   assign done    = busy && (count == CNT_W'(DATA_WIDTH - 2));

   // Shift-add datapath and bit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start && !busy) begin
         busy   <= 1'b1;
         count  <= '0;
         acc    <= b[0] ? P_W'(a) : '0;
         mcand  <= P_W'({a, 1'b0});
         mplier <= b >> 1;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_responder.sv
// ALU responder: accepts one op per ACT/ALU_RDY handshake and returns the
// result on EX_ALU/EX_ALU_VLD. Single-cycle ops stream at one per cycle,
// MULT runs on alu_mult_seq and holds ALU_RDY low until it completes.
// Optional: define ALU_CARRY_FLAG_EN to add the EX_CARRY output.
module alu_responder
   import alu_responder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ACT,
   input  logic [OP_W-1:0]       OP,
   input  logic [MOVI_W-1:0]     MOVI,
   input  logic [DATA_WIDTH-1:0] REG_A,
   input  logic [DATA_WIDTH-1:0] REG_B,
   input  logic [DATA_WIDTH-1:0] MEM,
   input  logic [DATA_WIDTH-1:0] IMM,
   output logic                  ALU_RDY,
   output logic [DATA_WIDTH-1:0] EX_ALU,
   output logic                  EX_ALU_VLD
`ifdef ALU_CARRY_FLAG_EN
   ,
   output logic                  EX_CARRY
`endif
);

   localparam int unsigned W = DATA_WIDTH;

   alu_state_t       state;
   alu_state_t       state_next;
   alu_op_t          op;
   logic             accept;
   logic             mult_start;
   logic             mult_busy;
   logic             mult_done;
   logic [2*W-1:0]   mult_prod;
   logic [W-1:0]     opb;
   logic [W-1:0]     alu_res;
   logic [W-1:0]     res_next;
   logic             rdy_next;
   logic             vld_next;

   assign op         = alu_op_t'(OP);
   assign accept     = ACT && ALU_RDY && !mult_busy;
   assign mult_start = accept && (op == OP_MULT);

   // Operand-B source mux
   always_comb begin
      opb = REG_B;
      case (alu_movi_t'(MOVI))
         MOVI_MEM: opb = MEM;
         MOVI_IMM: opb = IMM;
         default:  opb = REG_B;
      endcase
   end

   // Single-cycle result for every non-MULT opcode
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = REG_A + opb;
         OP_SUB:  alu_res = REG_A - opb;
         OP_SHL:  alu_res = {REG_A[W-2:0], 1'b0};
         OP_SHR:  alu_res = {1'b0, REG_A[W-1:1]};
         OP_ROL:  alu_res = {REG_A[W-2:0], REG_A[W-1]};
         OP_ROR:  alu_res = {REG_A[0], REG_A[W-1:1]};
         OP_NOT:  alu_res = ~REG_A;
         OP_AND:  alu_res = REG_A & opb;
         OP_OR:   alu_res = REG_A | opb;
         OP_XOR:  alu_res = REG_A ^ opb;
         OP_NAND: alu_res = ~(REG_A & opb);
         OP_NOR:  alu_res = ~(REG_A | opb);
         OP_XNOR: alu_res = ~(REG_A ^ opb);
         OP_INC:  alu_res = REG_A + W'(1);
         OP_DEC:  alu_res = REG_A - W'(1);
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_CARRY_FLAG_EN
   logic alu_cy;
   logic cy_next;

   // Carry/borrow/shifted-out bit for single-cycle ops
   always_comb begin
      alu_cy = 1'b0;
      case (op)
         OP_ADD:  alu_cy = (alu_res < REG_A);
         OP_SUB:  alu_cy = (REG_A < opb);
         OP_SHL:  alu_cy = REG_A[W-1];
         OP_ROL:  alu_cy = REG_A[W-1];
         OP_SHR:  alu_cy = REG_A[0];
         OP_ROR:  alu_cy = REG_A[0];
         OP_INC:  alu_cy = &REG_A;
         OP_DEC:  alu_cy = (REG_A == '0);
         default: alu_cy = 1'b0;
      endcase
   end
`else
   logic [W-1:0] unused_prod_hi;
   assign unused_prod_hi = mult_prod[2*W-1:W];
`endif

   alu_mult_seq #(
      .DATA_WIDTH (W)
   ) u_mult (
      .clk     (CLK),
      .rst     (RST),
      .start   (mult_start),
      .a       (REG_A),
      .b       (opb),
      .busy    (mult_busy),
      .done    (mult_done),
      .product (mult_prod)
   );

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mult_start) state_next = MUL;
         MUL:     if (mult_done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Next values for the registered outputs
   always_comb begin
      rdy_next = (state_next == IDLE);
      vld_next = 1'b0;
      res_next = alu_res;
`ifdef ALU_CARRY_FLAG_EN
      cy_next  = alu_cy;
`endif
      case (state)
         IDLE: begin
            if (accept && (op != OP_MULT)) begin
               vld_next = 1'b1;
            end
         end
         MUL: begin
            if (mult_done) begin
               vld_next = 1'b1;
               res_next = mult_prod[W-1:0];
`ifdef ALU_CARRY_FLAG_EN
               cy_next  = |mult_prod[2*W-1:W];
`endif
            end
         end
         default: vld_next = 1'b0;
      endcase
   end

   // Output registers; EX_ALU holds between valid pulses
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ALU_RDY    <= 1'b0;
         EX_ALU     <= '0;
         EX_ALU_VLD <= 1'b0;
`ifdef ALU_CARRY_FLAG_EN
         EX_CARRY   <= 1'b0;
`endif
      end else begin
         ALU_RDY    <= rdy_next;
         EX_ALU_VLD <= vld_next;
         if (vld_next) begin
            EX_ALU   <= res_next;
`ifdef ALU_CARRY_FLAG_EN
            EX_CARRY <= cy_next;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder (DATA_WIDTH=8): reset behaviour,
// a directed vector table, back-to-back streaming, MULT back-pressure,
// resets during/at an accept, and randomized ops against an arithmetic model.
module tb_alu_responder;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;
   localparam int MLAT = W;

   logic         CLK;
   logic         RST;
   logic         ACT;
   logic [3:0]   OP;
   logic [1:0]   MOVI;
   logic [W-1:0] REG_A, REG_B, MEM, IMM;
   logic         ALU_RDY;
   logic [W-1:0] EX_ALU;
   logic         EX_ALU_VLD;
`ifdef ALU_CARRY_FLAG_EN
   logic         EX_CARRY;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_responder #(.DATA_WIDTH(W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .ACT        (ACT),
      .OP         (OP),
      .MOVI       (MOVI),
      .REG_A      (REG_A),
      .REG_B      (REG_B),
      .MEM        (MEM),
      .IMM        (IMM),
      .ALU_RDY    (ALU_RDY),
      .EX_ALU     (EX_ALU),
      .EX_ALU_VLD (EX_ALU_VLD)
`ifdef ALU_CARRY_FLAG_EN
      ,
      .EX_CARRY   (EX_CARRY)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int op;
      int movi;
      int a;
      int regb;
      int mem;
      int imm;
      int res;
      int cy;
      int lat;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: plain integer arithmetic from the opcode definitions
   function automatic void model(input int op, input int a, input int b,
                                 output int res, output int cy);
      int full;
      res = 0;
      cy  = 0;
      case (op)
         0:  begin full = a + b; res = full & MASK; cy = (full > MASK) ? 1 : 0; end
         1:  begin res = (a - b) & MASK; cy = (a < b) ? 1 : 0; end
         2:  begin full = a * b; res = full & MASK; cy = (full > MASK) ? 1 : 0; end
         3:  begin res = (a * 2) & MASK; cy = a / (1 << (W - 1)); end
         4:  begin res = a / 2; cy = a % 2; end
         5:  begin res = ((a * 2) & MASK) + a / (1 << (W - 1)); cy = a / (1 << (W - 1)); end
         6:  begin res = a / 2 + (a % 2) * (1 << (W - 1)); cy = a % 2; end
         7:  res = MASK - a;
         8:  res = a & b;
         9:  res = a | b;
         10: res = a ^ b;
         11: res = MASK - (a & b);
         12: res = MASK - (a | b);
         13: res = MASK - (a ^ b);
         14: begin full = a + 1; res = full & MASK; cy = (full > MASK) ? 1 : 0; end
         default: begin res = (a - 1) & MASK; cy = (a == 0) ? 1 : 0; end
      endcase
   endfunction

   // Present one op, wait for acceptance, then wait for and check its result
   task automatic do_op(input string name, input vec_t v);
      int n;
      int rdy_bad;
      OP    = 4'(v.op);
      MOVI  = 2'(v.movi);
      REG_A = W'(v.a);
      REG_B = W'(v.regb);
      MEM   = W'(v.mem);
      IMM   = W'(v.imm);
      ACT   = 1'b1;
      n = 0;
      while (ALU_RDY !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (ALU_RDY !== 1'b1) check({name, " rdy timeout"}, 32'(ALU_RDY), 32'd1);
      step();
      ACT = 1'b0;
      n = 1;
      rdy_bad = 0;
      while (EX_ALU_VLD !== 1'b1 && n < 50) begin
         if (ALU_RDY !== 1'b0) rdy_bad++;
         step();
         n++;
      end
      check({name, " latency"}, 32'(n), 32'(v.lat));
      check({name, " result"}, 32'(EX_ALU), 32'(v.res));
      if (v.lat > 1) begin
         check({name, " rdy low while busy"}, 32'(rdy_bad), 32'd0);
         check({name, " rdy with vld"}, 32'(ALU_RDY), 32'd1);
      end
`ifdef ALU_CARRY_FLAG_EN
      check({name, " carry"}, 32'(EX_CARRY), 32'(v.cy));
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int res, cy, b;
      vec_t v;

      RST = 1'b1; ACT = 1'b0; OP = '0; MOVI = '0;
      REG_A = '0; REG_B = '0; MEM = '0; IMM = '0;

      // Reset state
      step(); step();
      check("reset rdy", 32'(ALU_RDY), 32'd0);
      check("reset vld", 32'(EX_ALU_VLD), 32'd0);
      check("reset ex_alu", 32'(EX_ALU), 32'd0);
      RST = 1'b0;
      #1;
      check("rdy before first edge", 32'(ALU_RDY), 32'd0);
      step();
      check("rdy after first edge", 32'(ALU_RDY), 32'd1);

      // Directed vector table: op, movi, a, regb, mem, imm, res, cy, lat
      tbl.push_back('{0,  0, 'hF0, 'h20, 'h00, 'h00, 'h10, 1, 1});
      tbl.push_back('{2,  2, 'h0F, 'h00, 'h00, 'h11, 'hFF, 0, 8});
      tbl.push_back('{2,  0, 'h10, 'h10, 'h00, 'h00, 'h00, 1, 8});
      tbl.push_back('{1,  3, 'h01, 'h03, 'h77, 'h55, 'hFE, 1, 1});
      tbl.push_back('{2,  1, 'h00, 'h00, 'h5A, 'h00, 'h00, 0, 8});
      tbl.push_back('{2,  0, 'hFF, 'hFF, 'h00, 'h00, 'h01, 1, 8});
      tbl.push_back('{14, 0, 'hFF, 'h00, 'h00, 'h00, 'h00, 1, 1});
      tbl.push_back('{4,  0, 'h03, 'h00, 'h00, 'h00, 'h01, 1, 1});
      tbl.push_back('{6,  0, 'h01, 'h00, 'h00, 'h00, 'h80, 1, 1});
      tbl.push_back('{3,  0, 'h40, 'h00, 'h00, 'h00, 'h80, 0, 1});
      tbl.push_back('{12, 2, 'h0F, 'h00, 'h00, 'hF0, 'h00, 0, 1});
      tbl.push_back('{11, 1, 'hF0, 'h00, 'h3C, 'h00, 'hCF, 0, 1});
      tbl.push_back('{13, 0, 'hA5, 'h5A, 'h00, 'h00, 'h00, 0, 1});
      tbl.push_back('{7,  0, 'h3C, 'h00, 'h00, 'h00, 'hC3, 0, 1});
      for (int i = 0; i < tbl.size(); i++) begin
         do_op($sformatf("vec%0d", i), tbl[i]);
      end

      // Back-to-back: XOR, ROL, DEC accepted on consecutive edges
      step();
      OP = 4'd10; MOVI = 2'd1; REG_A = 8'hAA; MEM = 8'hFF; ACT = 1'b1;
      step();
      check("b2b xor vld", 32'(EX_ALU_VLD), 32'd1);
      check("b2b xor res", 32'(EX_ALU), 32'h55);
      OP = 4'd5; MOVI = 2'd0; REG_A = 8'h81;
      step();
      check("b2b rol vld", 32'(EX_ALU_VLD), 32'd1);
      check("b2b rol res", 32'(EX_ALU), 32'h03);
`ifdef ALU_CARRY_FLAG_EN
      check("b2b rol carry", 32'(EX_CARRY), 32'd1);
`endif
      OP = 4'd15; REG_A = 8'h00;
      step();
      check("b2b dec vld", 32'(EX_ALU_VLD), 32'd1);
      check("b2b dec res", 32'(EX_ALU), 32'hFF);
      ACT = 1'b0;
      step();
      check("b2b vld drops", 32'(EX_ALU_VLD), 32'd0);
      check("b2b ex_alu holds", 32'(EX_ALU), 32'hFF);

      // MULT with the next op held on ACT throughout the busy period
      OP = 4'd2; MOVI = 2'd2; REG_A = 8'h0F; IMM = 8'h11; ACT = 1'b1;
      step();
      OP = 4'd0; MOVI = 2'd0; REG_A = 8'h01; REG_B = 8'h02;
      seen = 1;
      while (EX_ALU_VLD !== 1'b1 && seen < 50) begin
         step();
         seen++;
      end
      check("held mult latency", 32'(seen), 32'(MLAT));
      check("held mult res", 32'(EX_ALU), 32'hFF);
      check("held rdy after mult", 32'(ALU_RDY), 32'd1);
      step();
      check("held add vld", 32'(EX_ALU_VLD), 32'd1);
      check("held add res", 32'(EX_ALU), 32'h03);
      ACT = 1'b0;
      step();
      check("held add single pulse", 32'(EX_ALU_VLD), 32'd0);

      // Reset in the middle of a MULT aborts it
      OP = 4'd2; MOVI = 2'd0; REG_A = 8'hFF; REG_B = 8'hFF; ACT = 1'b1;
      step();
      ACT = 1'b0;
      step(); step(); step();
      #2 RST = 1'b1;
      #1;
      check("mid-mult rst rdy", 32'(ALU_RDY), 32'd0);
      check("mid-mult rst vld", 32'(EX_ALU_VLD), 32'd0);
      check("mid-mult rst ex_alu", 32'(EX_ALU), 32'd0);
      step(); step();
      RST = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (EX_ALU_VLD === 1'b1) seen++;
      end
      check("aborted mult no vld", 32'(seen), 32'd0);
      check("rdy after mid-mult rst", 32'(ALU_RDY), 32'd1);
      v = '{0, 0, 'h7F, 'h01, 'h00, 'h00, 'h80, 0, 1};
      do_op("after rst add", v);

      // Reset asserted on the same edge as an accept drops the op
      step();
      OP = 4'd14; REG_A = 8'h41; ACT = 1'b1;
      #8 RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      ACT = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (EX_ALU_VLD === 1'b1) seen++;
         step();
      end
      check("rst-vs-accept no vld", 32'(seen), 32'd0);
      check("rst-vs-accept ex_alu", 32'(EX_ALU), 32'd0);

      // Randomized ops against the model
      for (int i = 0; i < 300; i++) begin
         v.op   = int'($urandom_range(0, 15));
         v.movi = int'($urandom_range(0, 3));
         v.a    = int'($urandom_range(0, MASK));
         v.regb = int'($urandom_range(0, MASK));
         v.mem  = int'($urandom_range(0, MASK));
         v.imm  = int'($urandom_range(0, MASK));
         case ($urandom_range(0, 7))
            0: v.a = 0;
            1: v.a = MASK;
            2: begin v.regb = MASK; v.mem = MASK; v.imm = MASK; end
            3: begin v.regb = 0; v.mem = 0; v.imm = 0; end
            default: ;
         endcase
         b = (v.movi == 1) ? v.mem : (v.movi == 2) ? v.imm : v.regb;
         model(v.op, v.a, b, res, cy);
         v.res = res;
         v.cy  = cy;
         v.lat = (v.op == 2) ? MLAT : 1;
         do_op($sformatf("rand%0d op%0d", i, v.op), v);
         if ($urandom_range(0, 3) == 0) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
